bmc_acs_ctrl: RTL and testbench

Sequencing controller for the Viterbi decoder's branch-metric / add-compare-select array. It accepts received hard-decision symbol pairs over a valid/ready handshake and broadcasts each accepted pair to every branch-metric unit. Per symbol it fires the ACS update, path-metric normalisation and survivor-memory write, and hands completed survivor blocks to the traceback unit. It sits between the input symbol stream and the 64-state BMC/ACS bank.

---
 rtl/viterbi_pkg.sv | 17 +
 rtl/bmc_acs_ctrl_if.sv | 10 +
 rtl/bmc_acs_ctrl.sv | 92 +++++++++
 tb/tb_bmc_acs_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants and the BMC/ACS controller state encoding.
package viterbi_pkg;
    localparam int K          = 7;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam int PM_WIDTH   = 8;
    localparam int TB_DEPTH   = 32;
    localparam int SURV_AW    = $clog2(2 * TB_DEPTH);
    localparam int TB_LEN_W   = $clog2(TB_DEPTH + 1);
    localparam int BLK_W      = $clog2(TB_DEPTH);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        TB_REQ = 2'd2,
        DRAIN  = 2'd3
    } state_t;
endpackage

// File: rtl/bmc_acs_ctrl_if.sv
// Received symbol-pair stream: valid/ready handshake with a frame-end marker.
interface bmc_acs_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] rx_pair;
    logic       in_last;

    modport master (output in_valid, rx_pair, in_last, input in_ready);
    modport slave  (input in_valid, rx_pair, in_last, output in_ready);
endinterface

// File: rtl/bmc_acs_ctrl.sv
// Sequences symbol acceptance, ACS updates, survivor writes and traceback
// requests for the 64-state Viterbi BMC/ACS bank.
module bmc_acs_ctrl
    import viterbi_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    bmc_acs_ctrl_if.slave       sym,
    output logic [1:0]          bmc_rx_pair,
    output logic                acs_en,
    output logic                pm_init,
    input  logic                pm_all_msb,
    output logic                pm_norm,
    output logic                surv_we,
    output logic [SURV_AW-1:0]  surv_waddr,
    output logic                tb_start,
    output logic [SURV_AW-1:0]  tb_ptr,
    output logic [TB_LEN_W-1:0] tb_len,
    output logic                tb_final,
    input  logic                tb_busy,
    input  logic                tb_done
);
    state_t             state;
    logic [SURV_AW-1:0] wptr;
    logic [BLK_W-1:0]   blk_cnt;
    logic               accept;
    logic               blk_close;

    assign sym.in_ready = (state == RUN);
    assign accept       = sym.in_valid & sym.in_ready;
    assign blk_close    = (blk_cnt == BLK_W'(TB_DEPTH - 1)) | sym.in_last;

    // Normalisation rides on the same cycle as the ACS update it applies to.
    assign pm_init  = (state == INIT);
    assign tb_start = (state == TB_REQ) & ~tb_busy;
    assign pm_norm  = acs_en & pm_all_msb;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            wptr        <= '0;
            blk_cnt     <= '0;
            bmc_rx_pair <= '0;
            acs_en      <= 1'b0;
            surv_we     <= 1'b0;
            surv_waddr  <= '0;
            tb_ptr      <= '0;
            tb_len      <= '0;
            tb_final    <= 1'b0;
        end else begin
            acs_en  <= accept;
            surv_we <= accept;
            if (accept) begin
                bmc_rx_pair <= sym.rx_pair;
                surv_waddr  <= wptr;
            end

            case (state)
                INIT: begin
                    wptr     <= '0;
                    blk_cnt  <= '0;
                    tb_final <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        // Circular buffer of two traceback blocks.
                        wptr <= (wptr == SURV_AW'(2 * TB_DEPTH - 1)) ? '0 : wptr + 1'b1;
                        if (blk_close) begin
                            tb_ptr   <= wptr;
                            tb_len   <= TB_LEN_W'(blk_cnt) + 1'b1;
                            tb_final <= sym.in_last;
                            blk_cnt  <= '0;
                            state    <= TB_REQ;
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
                end
                TB_REQ: begin
                    if (!tb_busy) state <= tb_final ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (tb_done) state <= INIT;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bmc_acs_ctrl.sv
// Self-checking bench for bmc_acs_ctrl: directed boundary steps followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_bmc_acs_ctrl;
    import viterbi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          bmc_rx_pair;
    logic                acs_en, pm_init, pm_all_msb, pm_norm, surv_we;
    logic [SURV_AW-1:0]  surv_waddr, tb_ptr;
    logic [TB_LEN_W-1:0] tb_len;
    logic                tb_start, tb_final, tb_busy, tb_done;

    bmc_acs_ctrl_if sym ();

    bmc_acs_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym         (sym),
        .bmc_rx_pair (bmc_rx_pair),
        .acs_en      (acs_en),
        .pm_init     (pm_init),
        .pm_all_msb  (pm_all_msb),
        .pm_norm     (pm_norm),
        .surv_we     (surv_we),
        .surv_waddr  (surv_waddr),
        .tb_start    (tb_start),
        .tb_ptr      (tb_ptr),
        .tb_len      (tb_len),
        .tb_final    (tb_final),
        .tb_busy     (tb_busy),
        .tb_done     (tb_done)
    );

    // Reference model: a frame is a numbered symbol sequence; blocks close
    // every TB_DEPTH symbols or at the frame end, addresses are index mod 2*TB_DEPTH.
    typedef struct packed {
        logic [SURV_AW-1:0]  ptr;
        logic [TB_LEN_W-1:0] len;
        logic                fin;
    } req_t;

    req_t req_q[$];
    int   frame_sym;
    bit   m_init, m_drain, m_prev_acc;
    int   n_acc;
    bit   obs_ready, obs_start;
    int   checks, errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational outputs pre-edge, then registered ones post-edge.
    task automatic step(input bit v, input bit last, input bit busy, input bit done, input bit msb);
        bit                 exp_ready, exp_start, acc, next_init;
        logic [1:0]         pair;
        logic [SURV_AW-1:0] addr;
        req_t               r;
        pair          = 2'($urandom);
        sym.in_valid  = v;
        sym.rx_pair   = pair;
        sym.in_last   = last;
        tb_busy       = busy;
        tb_done       = done;
        pm_all_msb    = msb;
        #1;
        exp_ready = (req_q.size() == 0) && !m_drain && !m_init;
        exp_start = (req_q.size() != 0) && !busy;
        chk("pm_init", pm_init, m_init);
        chk("in_ready", sym.in_ready, exp_ready);
        chk("tb_start", tb_start, exp_start);
        chk("pm_norm", pm_norm, m_prev_acc & msb);
        obs_ready = sym.in_ready;
        obs_start = tb_start;
        if (exp_start) begin
            r = req_q[0];
            chk("tb_ptr", tb_ptr, r.ptr);
            chk("tb_len", tb_len, r.len);
            chk("tb_final", tb_final, r.fin);
        end

        acc       = v && exp_ready;
        addr      = '0;
        next_init = m_drain && done;
        if (m_init) frame_sym = 0;
        if (acc) begin
            addr = SURV_AW'(frame_sym % (2 * TB_DEPTH));
            if ((frame_sym % TB_DEPTH) == TB_DEPTH - 1 || last) begin
                r.ptr = addr;
                r.len = TB_LEN_W'(frame_sym % TB_DEPTH + 1);
                r.fin = last;
                req_q.push_back(r);
            end
            frame_sym++;
            n_acc++;
        end
        if (next_init) m_drain = 1'b0;
        if (exp_start) begin
            r = req_q.pop_front();
            if (r.fin) m_drain = 1'b1;
        end
        m_init = next_init;

        @(posedge clk);
        #1;
        chk("acs_en", acs_en, acc);
        chk("surv_we", surv_we, acc);
        if (acc) begin
            chk("bmc_rx_pair", bmc_rx_pair, pair);
            chk("surv_waddr", surv_waddr, addr);
        end
        m_prev_acc = acc;
    endtask

    task automatic do_reset(input int n);
        rst_n        = 1'b0;
        sym.in_valid = 1'b1;
        sym.in_last  = 1'b0;
        sym.rx_pair  = 2'b11;
        tb_busy      = 1'b0;
        tb_done      = 1'b1;
        pm_all_msb   = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_pm_init", pm_init, 1);
            chk("rst_in_ready", sym.in_ready, 0);
            chk("rst_acs_en", acs_en, 0);
            chk("rst_surv_we", surv_we, 0);
            chk("rst_tb_start", tb_start, 0);
            chk("rst_pm_norm", pm_norm, 0);
            chk("rst_tb_final", tb_final, 0);
            chk("rst_surv_waddr", surv_waddr, 0);
            chk("rst_tb_ptr", tb_ptr, 0);
            chk("rst_tb_len", tb_len, 0);
            chk("rst_bmc_rx_pair", bmc_rx_pair, 0);
        end
        rst_n = 1'b1;
        req_q.delete();
        m_init     = 1'b1;
        m_drain    = 1'b0;
        m_prev_acc = 1'b0;
        frame_sym  = 0;
    endtask

    task automatic send_n(input int n, input bit msb, input bit busy);
        int target;
        int budget;
        target = n_acc + n;
        budget = 0;
        while (n_acc < target && budget < 4 * n + 20) begin
            step(1'b1, 1'b0, busy, 1'b0, msb);
            budget++;
        end
    endtask

    int low, starts;

    initial begin
        checks = 0;
        errors = 0;
        n_acc  = 0;
        do_reset(3);

        // Idle after reset; pm_all_msb high with no ACS update must not normalise.
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // First full block: addresses 0..31, request on the 32nd update.
        send_n(TB_DEPTH, 1'b0, 1'b0);
        chk("blk0_ptr", tb_ptr, 31);
        chk("blk0_len", tb_len, 32);
        chk("blk0_final", tb_final, 0);
        low = 0;
        starts = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (!obs_ready) low++;
            starts += int'(obs_start);
        end while (!obs_ready && low < 10);
        chk("bubble_len", low, 1);
        chk("bubble_starts", starts, 1);

        // Second block closes at 63, third block wraps to address 0.
        send_n(31, 1'b0, 1'b0);
        chk("blk1_ptr", tb_ptr, 63);
        chk("blk1_len", tb_len, 32);
        send_n(1, 1'b0, 1'b0);
        chk("wrap_addr", surv_waddr, 0);
        send_n(5, 1'b1, 1'b0);

        // Traceback unit busy for 5 cycles at the next block boundary.
        send_n(26, 1'b0, 1'b1);
        chk("busy_blk_ptr", tb_ptr, 31);
        low = 0;
        starts = 0;
        repeat (5) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (!obs_ready) low++;
            starts += int'(obs_start);
        end
        do begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (!obs_ready) low++;
            starts += int'(obs_start);
        end while (!obs_ready && low < 20);
        chk("busy_ready_low", low, 6);
        chk("busy_starts", starts, 1);

        // tb_done while running is ignored.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Short frame: 5 symbols, last on the 5th.
        do_reset(2);
        send_n(4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("short_ptr", tb_ptr, 4);
        chk("short_len", tb_len, 5);
        chk("short_final", tb_final, 1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_n(1, 1'b0, 1'b0);
        chk("frame2_addr", surv_waddr, 0);

        // in_last on the TB_DEPTH-th symbol: exactly one final request.
        send_n(30, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        starts = 0;
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            starts += int'(obs_start);
        end
        chk("last32_starts", starts, 1);
        chk("last32_len", tb_len, 32);
        chk("last32_final", tb_final, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a block abandons it without a request.
        send_n(20, 1'b0, 1'b0);
        do_reset(2);
        starts = 0;
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            starts += int'(obs_start);
        end
        chk("midrst_starts", starts, 0);

        // Randomized traffic with busy, done and frame ends.
        repeat (1500) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
